// File: rtl/profile_buffer.sv
// Ping-pong row-offset store for the laser skeletonizer: captures one signed offset per row,
// publishes whole frames to the readout side via ready/ack and counts overrun drops.
module profile_buffer #(
    parameter int unsigned ROWS       = 480,
    parameter int unsigned CENTER_COL = 320,
    parameter int unsigned ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              row_done,
    input  logic [9:0]        current_row,
    input  logic [9:0]        midpoint,
    input  logic              first_row,
    output logic              frame_ready,
    input  logic              frame_ack,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [11:0]       rd_data,
    output logic [9:0]        rows_captured,
    output logic [10:0]       min_offset,
    output logic [10:0]       max_offset,
    output logic [7:0]        drop_count
);

    localparam int unsigned ROW_W  = 10;
    localparam int unsigned OFF_W  = 11;
    localparam int unsigned WORD_W = 12;
    localparam logic signed [OFF_W-1:0] MIN_INIT = 11'h3FF;  // +1023
    localparam logic signed [OFF_W-1:0] MAX_INIT = 11'h400;  // -1024

    logic [WORD_W-1:0] bank0 [ROWS];
    logic [WORD_W-1:0] bank1 [ROWS];

    logic                    wr_bank;
    logic                    first_row_q;
    logic [ROW_W-1:0]        work_cnt;
    logic signed [OFF_W-1:0] work_min;
    logic signed [OFF_W-1:0] work_max;
    logic                    work_any;

    logic                    row_ok;
    logic                    row_valid;
    logic signed [OFF_W-1:0] row_off;
    logic [WORD_W-1:0]       row_word;
    logic [ROW_W-1:0]        nxt_cnt;
    logic signed [OFF_W-1:0] nxt_min;
    logic signed [OFF_W-1:0] nxt_max;
    logic                    nxt_any;
    logic                    close_edge;
    logic                    publish;
    logic                    overrun;

    // Incoming row word and working statistics including this cycle's row
    always_comb begin
        row_ok     = row_done && ({1'b0, current_row} < (ROW_W + 1)'(ROWS));
        row_valid  = (midpoint != '0);
        row_off    = row_valid ? (OFF_W'(midpoint) - OFF_W'(CENTER_COL)) : '0;
        row_word   = {row_valid, row_off};
        nxt_cnt    = work_cnt;
        nxt_min    = work_min;
        nxt_max    = work_max;
        nxt_any    = work_any;
        if (row_ok && ({1'b0, work_cnt} < (ROW_W + 1)'(ROWS))) begin
            nxt_cnt = work_cnt + ROW_W'(1);
        end
        if (row_ok && row_valid) begin
            nxt_any = 1'b1;
            if (row_off < work_min) nxt_min = row_off;
            if (row_off > work_max) nxt_max = row_off;
        end
        close_edge = first_row && !first_row_q;
        publish    = close_edge && (!frame_ready || frame_ack);
        overrun    = close_edge && frame_ready && !frame_ack;
    end

    // Tracks first_row even in reset so a level held across reset is not seen as an edge
    always_ff @(posedge clk) begin
        first_row_q <= first_row;
    end

    always_ff @(posedge clk) begin
        if (row_ok) begin
            if (wr_bank) bank1[current_row[ADDR_W-1:0]] <= row_word;
            else         bank0[current_row[ADDR_W-1:0]] <= row_word;
        end
    end

    // Reads use the pre-swap bank, so a read on the swap edge returns the old frame
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if ({1'b0, rd_addr} < (ADDR_W + 1)'(ROWS)) begin
                rd_data <= wr_bank ? bank0[rd_addr] : bank1[rd_addr];
            end else begin
                rd_data <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank       <= 1'b0;
            frame_ready   <= 1'b0;
            rows_captured <= '0;
            min_offset    <= '0;
            max_offset    <= '0;
            drop_count    <= '0;
            work_cnt      <= '0;
            work_min      <= MIN_INIT;
            work_max      <= MAX_INIT;
            work_any      <= 1'b0;
        end else begin
            if (close_edge) begin
                work_cnt <= '0;
                work_min <= MIN_INIT;
                work_max <= MAX_INIT;
                work_any <= 1'b0;
            end else begin
                work_cnt <= nxt_cnt;
                work_min <= nxt_min;
                work_max <= nxt_max;
                work_any <= nxt_any;
            end

            if (publish) begin
                wr_bank       <= ~wr_bank;
                frame_ready   <= 1'b1;
                rows_captured <= nxt_cnt;
                min_offset    <= nxt_any ? nxt_min : '0;
                max_offset    <= nxt_any ? nxt_max : '0;
            end else if (overrun) begin
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else if (frame_ack) begin
                frame_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_profile_buffer.sv
// Directed plus randomized bench for profile_buffer against a frame-level reference model.
module tb_profile_buffer;

    localparam int ROWS       = 480;
    localparam int CENTER_COL = 320;
    localparam int ADDR_W     = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              row_done;
    logic [9:0]        current_row;
    logic [9:0]        midpoint;
    logic              first_row;
    logic              frame_ready;
    logic              frame_ack;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [11:0]       rd_data;
    logic [9:0]        rows_captured;
    logic [10:0]       min_offset;
    logic [10:0]       max_offset;
    logic [7:0]        drop_count;

    always #5 clk = ~clk;

    profile_buffer #(.ROWS(ROWS), .CENTER_COL(CENTER_COL), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .row_done(row_done), .current_row(current_row),
        .midpoint(midpoint), .first_row(first_row), .frame_ready(frame_ready),
        .frame_ack(frame_ack), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rows_captured(rows_captured), .min_offset(min_offset), .max_offset(max_offset),
        .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the frame being built and the frame handed to the consumer
    logic [11:0] work_val [ROWS];
    bit          work_wr  [ROWS];
    int          work_cnt, work_min, work_max;
    bit          work_any;
    logic [11:0] com_val  [ROWS];
    bit          com_wr   [ROWS];
    int          com_cnt, com_min, com_max;
    bit          ready;
    int          drops;
    logic [11:0] exp_rd;
    bit          exp_rd_known;
    bit          prev_fr;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_work();
        for (int i = 0; i < ROWS; i++) work_wr[i] = 1'b0;
        work_cnt = 0;
        work_min = 1023;
        work_max = -1024;
        work_any = 1'b0;
    endtask

    task automatic check_outputs();
        chk("frame_ready", int'(frame_ready), int'(ready));
        chk("rows_captured", int'(rows_captured), com_cnt);
        chk("min_offset", int'($signed(min_offset)), com_min);
        chk("max_offset", int'($signed(max_offset)), com_max);
        chk("drop_count", int'(drop_count), drops);
        if (exp_rd_known) chk("rd_data", int'(rd_data), int'(exp_rd));
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge
    task automatic cycle(input bit rd, input int row, input int mid, input bit fr,
                         input bit ack, input bit ren, input int raddr);
        bit          cl;
        int          off;
        logic [10:0] o11;
        row_done    = rd;
        current_row = 10'(row);
        midpoint    = 10'(mid);
        first_row   = fr;
        frame_ack   = ack;
        rd_en       = ren;
        rd_addr     = ADDR_W'(raddr);

        if (ren) begin
            if (raddr >= ROWS) begin
                exp_rd = '0;
                exp_rd_known = 1'b1;
            end else begin
                exp_rd = com_val[raddr];
                exp_rd_known = com_wr[raddr];
            end
        end
        cl = fr && !prev_fr;
        prev_fr = fr;
        if (rd && row < ROWS) begin
            off = (mid != 0) ? mid - CENTER_COL : 0;
            o11 = 11'(off);
            work_val[row] = {mid != 0, o11};
            work_wr[row] = 1'b1;
            if (work_cnt < ROWS) work_cnt++;
            if (mid != 0) begin
                work_any = 1'b1;
                if (off < work_min) work_min = off;
                if (off > work_max) work_max = off;
            end
        end
        if (cl) begin
            if (!ready || ack) begin
                com_val = work_val;
                com_wr  = work_wr;
                com_cnt = work_cnt;
                com_min = work_any ? work_min : 0;
                com_max = work_any ? work_max : 0;
                ready   = 1'b1;
            end else if (drops < 255) begin
                drops++;
            end
            clear_work();
        end else if (ack) begin
            ready = 1'b0;
        end

        @(posedge clk);
        #1;
        check_outputs();
        row_done  = 1'b0;
        frame_ack = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        row_done = 1'b0; frame_ack = 1'b0; rd_en = 1'b0;
        current_row = '0; midpoint = '0; rd_addr = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        prev_fr = first_row;
        clear_work();
        for (int i = 0; i < ROWS; i++) com_wr[i] = 1'b0;
        com_cnt = 0; com_min = 0; com_max = 0;
        ready = 1'b0; drops = 0;
        exp_rd = '0; exp_rd_known = 1'b1;
        reset = 1'b0;
        check_outputs();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic close(input bit ack);
        cycle(0, 0, 0, 1, ack, 0, 0);
        idle();
    endtask

    int n, r, m;

    initial begin
        first_row = 1'b0;
        do_reset();

        // Single frame: midpoints 330, 0, 300
        cycle(1, 0, 330, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 2, 300, 0, 0, 0, 0);
        close(0);
        chk("sf_ready", int'(frame_ready), 1);
        chk("sf_rows", int'(rows_captured), 3);
        chk("sf_min", int'($signed(min_offset)), -20);
        chk("sf_max", int'($signed(max_offset)), 10);
        cycle(0, 0, 0, 0, 0, 1, 0);
        chk("sf_row0", int'(rd_data), 'h80A);
        cycle(0, 0, 0, 0, 0, 1, 1);
        chk("sf_row1", int'(rd_data), 0);
        cycle(0, 0, 0, 0, 0, 1, 2);
        chk("sf_row2", int'(rd_data), 'hFEC);
        cycle(0, 0, 0, 0, 0, 1, 480);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 511);

        // Out-of-range row only: empty frame publishes zero count and zero extrema
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 480, 400, 0, 0, 0, 0);
        close(0);
        chk("oor_rows", int'(rows_captured), 0);

        // Extreme midpoints and an all-invalid row
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 7, 1023, 0, 0, 0, 0);
        cycle(1, 8, 1, 0, 0, 0, 0);
        cycle(1, 9, 0, 0, 0, 0, 0);
        close(1);
        chk("ext_max", int'($signed(max_offset)), 703);
        chk("ext_min", int'($signed(min_offset)), -319);
        for (int a = 7; a < 10; a++) cycle(0, 0, 0, 0, 0, 1, a);

        // Overrun: B is dropped while A is still pending, then C publishes after ack
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 3, 350, 0, 0, 0, 0);
        close(0);
        cycle(1, 3, 200, 0, 0, 0, 0);
        cycle(1, 4, 210, 0, 0, 0, 0);
        close(0);
        chk("ovr_drop", int'(drop_count), 1);
        cycle(0, 0, 0, 0, 0, 1, 3);
        chk("ovr_keepA", int'(rd_data), 'h81E);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 6, 330, 0, 0, 0, 0);
        close(0);
        cycle(0, 0, 0, 0, 0, 1, 6);

        // Ack coincident with close edge: publishes, ready stays high, no drop
        cycle(1, 2, 340, 0, 0, 0, 0);
        close(1);
        chk("ackc_ready", int'(frame_ready), 1);
        chk("ackc_drop", int'(drop_count), 1);

        // Row on the closing edge belongs to the closing frame
        cycle(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, i, 310 + i, 0, 0, 0, 0);
        cycle(1, 5, 321, 1, 0, 1, 0);
        idle();
        cycle(0, 0, 0, 0, 0, 1, 5);
        chk("coinc_row5", int'(rd_data), 'h801);
        chk("coinc_rows", int'(rows_captured), 6);

        // Randomized frames with random acks, reads and out-of-range rows
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) begin
                r = ($urandom_range(0, 9) == 0) ? $urandom_range(ROWS, 1023) : $urandom_range(0, 29);
                m = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 1023);
                cycle($urandom_range(0, 3) != 0, r, m, 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 511));
            end
            r = $urandom_range(0, 29);
            m = $urandom_range(0, 1023);
            cycle($urandom_range(0, 1) == 1, r, m, 1, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 29));
            idle();
            for (int a = 0; a < 30; a++) cycle(0, 0, 0, 0, 0, 1, a);
        end

        // Drop counter saturation
        for (int i = 0; i < 260; i++) begin
            cycle(1, 0, 100, 1, 0, 0, 0);
            idle();
        end
        chk("drop_sat", int'(drop_count), 255);

        // Reset mid-frame after 10 rows; next frame holds only its own rows
        for (int i = 0; i < 10; i++) cycle(1, i, 400, 0, 0, 0, 0);
        do_reset();
        chk("rst_ready", int'(frame_ready), 0);
        chk("rst_rdata", int'(rd_data), 0);
        for (int i = 0; i < 4; i++) cycle(1, 20 + i, 330 - i, 0, 0, 0, 0);
        close(0);
        chk("rst_rows", int'(rows_captured), 4);
        for (int a = 20; a < 24; a++) cycle(0, 0, 0, 0, 0, 1, a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/profile_buffer.md
# profile_buffer

Downstream consumer of the per-row laser skeletonizer. Captures one signed column offset per image row (laser midpoint minus optical centre column) into a ping-pong row memory, closes each frame on the skeletonizer's frame marker, and publishes the finished profile to the depth/readout logic through a ready/ack handshake with overrun accounting. Also reports per-frame row count and offset extrema.

## Interface
- ROWS, 480: rows stored per frame; rows with index >= ROWS are discarded.
- CENTER_COL, 320: column subtracted from each midpoint.
- ADDR_W, 9: row address width; 2^ADDR_W >= ROWS.
- clk  in  1  system clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous active-high reset.
- row_done  in  1  one-cycle pulse: midpoint/current_row valid for a completed row.
- current_row  in  10  row index of the completed row.
- midpoint  in  10  laser centre column; 0 = no laser found.
- first_row  in  1  high from frame start until the first row completes; its 0->1 edge closes the frame.
- frame_ready  out  1  committed bank holds a complete, unacknowledged frame.
- frame_ack  in  1  one-cycle pulse from the consumer releasing the committed frame.
- rd_en  in  1  read strobe on the committed bank.
- rd_addr  in  ADDR_W  row to read.
- rd_data  out  12  {valid, offset[10:0]} two's complement, registered.
- rows_captured  out  10  rows written in the committed frame.
- min_offset, max_offset  out  11 each  signed extrema over valid rows of the committed frame.
- drop_count  out  8  frames discarded due to overrun, saturating at 255.

## Operation
- Two banks of ROWS x 12 bits; wr_bank and rd_bank = ~wr_bank. Reset: wr_bank=0.
- Row capture: on row_done with current_row < ROWS, write word to wr_bank[current_row]: valid = (midpoint != 0); offset = {1'b0,midpoint} - CENTER_COL in 11 bits (range -CENTER_COL..1023-CENTER_COL, no overflow for CENTER_COL <= 1023); offset forced to 0 when invalid. Increment working row count (saturates at ROWS); update working min/max only when valid. Rows >= ROWS: no write, no count.
- Working extrema initialise to min=+1023, max=-1024 at frame open; if a frame closes with no valid row, published min_offset = max_offset = 0.
- Frame close: detected as first_row rising (registered previous value). Actions:
  - frame_ready=0 (or ack this cycle): swap banks, publish rows_captured/min/max from working registers, set frame_ready=1.
  - frame_ready=1 with no ack this cycle: overrun; no swap, committed frame and outputs unchanged, drop_count+1 (saturating), working bank reused.
  - Either way, working count and extrema reset for the new frame.
- Unwritten rows in the write bank are not cleared; consumer must use rows_captured / valid bit.
- frame_ack: clears frame_ready next cycle; ack while frame_ready=0 ignored.
- Reads: always legal; rd_data reflects rd_bank at rd_addr. rd_addr >= ROWS returns 0.
- Reset mid-frame: partial frame discarded, frame_ready=0, all counters/extrema/rd_data = 0, wr_bank=0; memory contents undefined but unreachable until the next publish.

## Timing
- Row write lands 1 cycle after row_done; readable only after the frame is published.
- Close edge: first_row high in cycle N (low in N-1) -> swap and frame_ready=1 visible at N+1.
- Simultaneous row_done and close edge in same cycle: the row belongs to the closing frame (included in published count/extrema and written before swap).
- Simultaneous frame_ack and close edge: ack honoured first; frame publishes, frame_ready remains 1 at N+1, no drop.
- rd_data latency 1 cycle after rd_en; rd_data holds when rd_en=0. Read in same cycle as swap returns old rd_bank data.
- Throughput: one row_done per cycle supported.

## Test plan
- Single frame: rows 0..2 with midpoints 330, 0, 300, then close -> frame_ready=1; rd_data row0={1,+10}, row1={0,0}, row2={1,-20}; rows_captured=3; min=-20, max=+10.
- Out-of-range row: row_done with current_row=480 midpoint 400 -> no write, rows_captured unchanged.
- Overrun: publish frame A, do not ack, complete frame B -> drop_count=1, rd_data still frame A; ack, complete C -> C published.
- Ack coincident with close edge -> new frame published, frame_ready stays 1, drop_count=0.
- Row_done coincident with close edge (row 5, midpoint 321) -> row 5 = {1,+1} in published frame.
- Reset asserted mid-frame after 10 rows -> all outputs 0; next full frame publishes only its own rows.
